// File: rtl/code_loader_pkg.sv
// code_loader_pkg: shared code-memory geometry and loader state encoding.
package code_loader_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_VERIFY = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        VERIFY = ST_VERIFY,
        CHECK  = ST_CHECK,
        RUN    = ST_RUN,
        ERR    = ST_ERR
    } state_t;

endpackage

// File: rtl/code_loader_word_checksum.sv
// word_checksum: registered modular additive checksum with synchronous clear.
module word_checksum #(
    parameter int DATA_W = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_add_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_sum
);

    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear)
            r_sum <= '0;
        else if (i_add_en)
            r_sum <= r_sum + i_data;
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/code_loader.sv
// code_loader: streams a program into code memory, verifies its checksum, then releases the CPU.
import code_loader_pkg::*;

module code_loader #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    input  logic [DATA_W-1:0] i_expected_sum,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [ADDR_W-1:0] o_mem_write_select,
    output logic [DATA_W-1:0] o_mem_inp,
    output logic              o_mem_write_en,
    output logic [ADDR_W-1:0] o_mem_read_select,
    input  logic [DATA_W-1:0] i_mem_instruction,
    input  logic [ADDR_W-1:0] i_cpu_pc,
    output logic              o_cpu_halt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam int LEN_W = ADDR_W + 1;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_exp_sum, w_sum;
    logic              w_accept, w_len_bad, w_load_go, w_xfer, w_wr_last, w_rd_last;

    assign w_accept  = i_start && (r_state == IDLE || r_state == RUN || r_state == ERR);
    assign w_len_bad = (i_len == '0) || (i_len > LEN_W'(DEPTH));
    assign w_load_go = w_accept && !w_len_bad;
    assign w_xfer    = (r_state == LOAD) && i_in_valid;
    // Last-address compares are done at LEN_W so len==DEPTH needs no wrap handling.
    assign w_wr_last = {1'b0, r_wr_addr} == r_len - LEN_W'(1);
    assign w_rd_last = {1'b0, r_rd_addr} == r_len - LEN_W'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, RUN, ERR: if (i_start) w_next = w_len_bad ? ERR : LOAD;
            LOAD:           if (w_xfer && w_wr_last) w_next = VERIFY;
            VERIFY:         if (w_rd_last) w_next = CHECK;
            CHECK:          w_next = (w_sum == r_exp_sum) ? RUN : ERR;
            default:        w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_len     <= '0;
            r_exp_sum <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_go) begin
                r_len     <= i_len;
                r_exp_sum <= i_expected_sum;
                r_wr_addr <= '0;
                r_rd_addr <= '0;
            end else begin
                if (w_xfer) r_wr_addr <= r_wr_addr + ADDR_W'(1);
                if (r_state == VERIFY) r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
        end
    end

    word_checksum #(.DATA_W(DATA_W)) u_sum (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (w_load_go),
        .i_add_en(r_state == VERIFY),
        .i_data  (i_mem_instruction),
        .o_sum   (w_sum)
    );

    assign o_in_ready         = (r_state == LOAD);
    assign o_mem_write_en     = w_xfer;
    assign o_mem_write_select = r_wr_addr;
    assign o_mem_inp          = i_in_data;
    assign o_mem_read_select  = (r_state == VERIFY) ? r_rd_addr : i_cpu_pc;
    assign o_cpu_halt         = (r_state != RUN);
    assign o_busy             = (r_state == LOAD) || (r_state == VERIFY) || (r_state == CHECK);
    assign o_done             = (r_state == RUN);
    assign o_error            = (r_state == ERR);

endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader: directed stimulus with a write scoreboard and a behavioural code memory.
module tb_code_loader;

    logic        clk = 0, rst = 0, start = 0, in_valid = 0;
    logic [6:0]  len = 0;
    logic [15:0] exp_sum = 0, in_data = 0;
    logic        in_ready, we, halt, busy, done, error;
    logic [5:0]  wsel, rsel, cpu_pc = 0;
    logic [15:0] minp, minst;
    logic [15:0] mem [64] = '{default: 16'h0};
    logic [15:0] prog [64];
    logic [21:0] wq [$];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    code_loader dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_len(len),
        .i_expected_sum(exp_sum), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(in_ready), .o_mem_write_select(wsel), .o_mem_inp(minp),
        .o_mem_write_en(we), .o_mem_read_select(rsel), .i_mem_instruction(minst),
        .i_cpu_pc(cpu_pc), .o_cpu_halt(halt), .o_busy(busy), .o_done(done), .o_error(error)
    );

    always @(posedge clk) if (we) mem[wsel] <= minp;
    assign minst = mem[rsel];

    // Write monitor: every strobe must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (we) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected got addr=%0d data=%h expected none", wsel, minp);
            end else begin
                logic [21:0] e;
                e = wq.pop_front();
                if ({wsel, minp} !== e) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             wsel, minp, e[21:16], e[15:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic do_start(input logic [6:0] l, input logic [15:0] s);
        start = 1; len = l; exp_sum = s;
        tick();
        start = 0;
    endtask

    task automatic load_prog(input int n, input bit gap, input int poke);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                in_valid = 0;
                tick();
            end
            in_valid = 1; in_data = prog[i];
            wq.push_back({6'(i), prog[i]});
            if (i == poke) begin
                start = 1; len = 0;
            end
            tick();
            start = 0;
        end
        in_valid = 0;
    endtask

    task automatic wait_end(input string name, input bit want_done);
        int n;
        n = 0;
        while (!done && !error && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL %s_timeout got=busy expected=done_or_error", name);
        end else
            chk(name, {done, error, halt}, want_done ? 32'b100 : 32'b011);
    endtask

    task automatic set_prog3;
        prog[0] = 16'h3000; prog[1] = 16'h8C09; prog[2] = 16'h3400;
    endtask

    initial begin
        rst = 1; tick(); tick(); rst = 0;
        repeat (5) tick();
        chk("reset_halt", halt, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_we", we, 0);

        // Back-to-back load with cycle-exact timing: RUN 8 edges after start.
        set_prog3();
        do_start(3, 16'hF009);
        chk("load_in_ready", in_ready, 1);
        chk("load_busy", busy, 1);
        load_prog(3, 0, -1);
        chk("mem0", mem[0], 16'h3000);
        chk("mem2", mem[2], 16'h3400);
        for (int i = 0; i < 3; i++) begin
            chk("verify_rsel", rsel, i);
            chk("verify_no_ready", in_ready, 0);
            tick();
        end
        chk("check_busy", {busy, halt, done}, 3'b110);
        tick();
        chk("run_done", {done, halt, busy}, 3'b100);
        cpu_pc = 6'd5;  #1 chk("run_rsel_pc5", rsel, 5);
        cpu_pc = 6'd42; #1 chk("run_rsel_pc42", rsel, 42);

        // Gapped stream: only valid cycles write, addresses contiguous.
        do_start(3, 16'hF009);
        chk("rerun_halt", halt, 1);
        load_prog(3, 1, -1);
        wait_end("gapped_run", 1);

        // Wrong checksum, then recovery.
        do_start(3, 16'h0000);
        load_prog(3, 0, -1);
        wait_end("badsum_err", 0);
        do_start(3, 16'hF009);
        load_prog(3, 0, -1);
        wait_end("recover_run", 1);

        // len boundaries.
        do_start(0, 16'h0000);
        chk("len0_err", {error, busy, halt}, 3'b101);
        rst = 1; tick(); rst = 0;
        chk("reset_idle", {error, done, halt}, 3'b001);
        do_start(65, 16'h0000);
        chk("len65_err", {error, busy, halt}, 3'b101);
        for (int i = 0; i < 64; i++) prog[i] = 16'h0001;
        do_start(64, 16'h0040);
        load_prog(64, 0, -1);
        chk("len64_mem63", mem[63], 16'h0001);
        wait_end("len64_run", 1);

        // Start during LOAD (len=0) must not restart or abort.
        prog[0] = 16'h0102; prog[1] = 16'h0304; prog[2] = 16'h0506;
        do_start(3, 16'h090C);
        load_prog(3, 0, 1);
        chk("start_in_load_busy", {busy, error}, 2'b10);
        wait_end("start_in_load_run", 1);

        // Reset mid-VERIFY.
        prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333;
        do_start(3, 16'h6666);
        load_prog(3, 0, -1);
        tick();
        chk("midverify_busy", busy, 1);
        rst = 1; tick(); rst = 0;
        chk("midreset_state", {busy, done, error, halt, in_ready}, 5'b00010);
        chk("midreset_mem0", mem[0], 16'h1111);
        chk("midreset_mem2", mem[2], 16'h3333);
        chk("midreset_mem3", mem[3], 16'h0001);

        tick();
        chk("write_queue_empty", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
